// File: rtl/binary_divider_v.sv
// Unsigned divider by repeated subtraction.
// One subtraction per clock; QUOT/REM/DIV_ZERO are registered and DONE strobes for one cycle.
module binary_divider_v #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_ZERO
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUB  = 2'b01,
    FIN  = 2'b10
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] ar, ar_nx;
  logic [WIDTH-1:0] br, br_nx;
  logic [WIDTH-1:0] qr, qr_nx;
  logic [WIDTH-1:0] quot_nx, rem_nx;
  logic             done_nx, dz_nx;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      ar       <= '0;
      br       <= '0;
      qr       <= '0;
      QUOT     <= '0;
      REM      <= '0;
      DONE     <= 1'b0;
      DIV_ZERO <= 1'b0;
    end else begin
      state    <= state_nx;
      ar       <= ar_nx;
      br       <= br_nx;
      qr       <= qr_nx;
      QUOT     <= quot_nx;
      REM      <= rem_nx;
      DONE     <= done_nx;
      DIV_ZERO <= dz_nx;
    end
  end

  // Divide-by-zero skips SUB entirely and reports from FIN like a normal result.
  always_comb begin
    state_nx = state;
    ar_nx    = ar;
    br_nx    = br;
    qr_nx    = qr;
    quot_nx  = QUOT;
    rem_nx   = REM;
    done_nx  = 1'b0;
    dz_nx    = DIV_ZERO;
    case (state)
      IDLE: begin
        if (START) begin
          if (B != '0) begin
            ar_nx    = A;
            br_nx    = B;
            qr_nx    = '0;
            dz_nx    = 1'b0;
            state_nx = SUB;
          end else begin
            quot_nx  = '1;
            rem_nx   = A;
            dz_nx    = 1'b1;
            done_nx  = 1'b1;
            state_nx = FIN;
          end
        end
      end
      SUB: begin
        if (ar >= br) begin
          ar_nx = ar - br;
          qr_nx = qr + WIDTH'(1);
        end else begin
          quot_nx  = qr;
          rem_nx   = ar;
          done_nx  = 1'b1;
          state_nx = FIN;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign BUSY = (state == SUB) || (state == FIN);

endmodule

// File: tb/tb_binary_divider_v.sv
// Self-checking bench for binary_divider_v: directed vector table, corner sequences,
// and random operands checked against a plain-arithmetic division model.
module tb_binary_divider_v;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [7:0] QUOT, REM;
  logic       BUSY, DONE, DIV_ZERO;

  int total = 0;
  int bad = 0;

  binary_divider_v #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .A(A), .B(B),
    .QUOT(QUOT), .REM(REM), .BUSY(BUSY), .DONE(DONE), .DIV_ZERO(DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one operation and follows it to completion; lat = edges from e0 to DONE.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] eq, input logic [7:0] er,
                                input logic edz, input int elat,
                                input int glitch_at, input string tag);
    int  edges;
    bit  busy_ok;
    bit  timed_out;
    START = 1'b1; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0;
    if (b != 0) check_output({tag, "_dz_clear"}, DIV_ZERO, 0);
    edges = 0; busy_ok = 1; timed_out = 0;
    while (!DONE) begin
      if (edges + 1 == glitch_at) begin
        START = 1'b1; A = 8'd1; B = 8'd1;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
      edges++;
      if (!DONE && !BUSY) busy_ok = 0;
      if (edges > 600) begin
        timed_out = 1;
        break;
      end
    end
    START = 1'b0;
    if (timed_out) begin
      check_output({tag, "_timeout"}, edges, elat);
      return;
    end
    check_output({tag, "_latency"}, edges, elat);
    check_output({tag, "_quot"}, QUOT, eq);
    check_output({tag, "_rem"}, REM, er);
    check_output({tag, "_dz"}, DIV_ZERO, edz);
    check_output({tag, "_busy_fin"}, BUSY, 1);
    if (b != 0) check_output({tag, "_busy_sub"}, busy_ok, 1);
    @(posedge CLK); #1;
    check_output({tag, "_done_drop"}, DONE, 0);
    check_output({tag, "_idle"}, BUSY, 0);
    check_output({tag, "_quot_hold"}, QUOT, eq);
  endtask

  initial begin
    vec_t vecs[6];
    logic [7:0] ra, rb, mq, mr;
    logic       mdz;
    int         mlat;

    vecs[0] = '{8'd13,  8'd4,   8'd3,   8'd1, 1'b0, 4};
    vecs[1] = '{8'd0,   8'd5,   8'd0,   8'd0, 1'b0, 1};
    vecs[2] = '{8'd3,   8'd200, 8'd0,   8'd3, 1'b0, 1};
    vecs[3] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 256};
    vecs[4] = '{8'd7,   8'd0,   8'hFF,  8'd7, 1'b1, 0};
    vecs[5] = '{8'd9,   8'd3,   8'd3,   8'd0, 1'b0, 4};

    #12;
    check_output("reset_quot", QUOT, 0);
    check_output("reset_rem", REM, 0);
    check_output("reset_busy", BUSY, 0);
    check_output("reset_done", DONE, 0);
    check_output("reset_dz", DIV_ZERO, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 6; i++)
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
                     vecs[i].lat, -1, $sformatf("vec%0d", i));

    // Second START at e5 must be ignored while busy.
    apply_stimulus(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 15, 5, "glitch");

    // Asynchronous reset in the middle of SUB.
    START = 1'b1; A = 8'd200; B = 8'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    check_output("rst_mid_quot", QUOT, 0);
    check_output("rst_mid_rem", REM, 0);
    check_output("rst_mid_busy", BUSY, 0);
    check_output("rst_mid_done", DONE, 0);
    check_output("rst_mid_dz", DIV_ZERO, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check_output("rst_no_done", DONE, 0);
    apply_stimulus(8'd6, 8'd2, 8'd3, 8'd0, 1'b0, 4, -1, "post_rst");

    // Random operands against the arithmetic model.
    for (int n = 0; n < 25; n++) begin
      ra = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rb = 8'd0;
      else if ($urandom_range(0, 1) == 0) rb = 8'($urandom_range(1, 15));
      else rb = 8'($urandom_range(1, 255));
      if (rb == 0) begin
        mq = 8'hFF; mr = ra; mdz = 1'b1; mlat = 0;
      end else begin
        mq = ra / rb; mr = ra % rb; mdz = 1'b0; mlat = int'(mq) + 1;
      end
      apply_stimulus(ra, rb, mq, mr, mdz, mlat, -1, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
